// File: rtl/adc_frame_packer.sv
// adc_frame_packer: converts 10-bit offset-binary ADC samples into signed
// complex FFT input words and frames them as an AXI-stream with tlast every
// FRAME_LEN beats. A small first-word-fall-through skid FIFO sits between
// the sample strobe and the stream so the FFT core may apply backpressure.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | not capturing; samples discarded, start arms capture
// RUN   | samples written to the FIFO, input count advances per strobe
// DRAIN | last frame captured, waiting for its tlast beat to leave
module adc_frame_packer #(
   parameter int FRAME_LEN    = 1024,
   parameter int FIFO_DEPTH   = 16,
   parameter bit CONT_DEFAULT = 1'b1
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [9:0]  ad_data,
   input  logic        ad_valid,
   input  logic        start,
   input  logic        cont_mode,
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        busy,
   output logic        overflow,
   output logic [15:0] frame_cnt
);

   localparam int CW = $clog2(FRAME_LEN);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t          state;
   logic [CW-1:0]   in_cnt;
   logic [CW-1:0]   beat_cnt;
   logic            cont_q;
   logic            cont_next;
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;
   logic [15:0]     mem [FIFO_DEPTH];
   logic [15:0]     sample_real;
   logic            fifo_empty;
   logic            fifo_full;
   logic            rd_en;
   logic            wr_en;
   logic            drop;
   logic            in_last;

   // Offset binary to two's complement: flip the MSB, then sign-extend.
   assign sample_real = {{6{~ad_data[9]}}, ~ad_data[9], ad_data[8:0]};

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign rd_en   = m_axis_tvalid && m_axis_tready;
   // A read in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_en   = (state == RUN) && ad_valid && (!fifo_full || rd_en);
   assign drop    = (state == RUN) && ad_valid && fifo_full && !rd_en;
   assign in_last = (in_cnt == LAST_IDX);

   // Mode register only picks up cont_mode on the frame-end strobe.
   assign cont_next = ((state == RUN) && ad_valid && in_last) ? cont_mode : cont_q;

   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = fifo_empty ? 32'h0 : {16'h0000, mem[rd_ptr[AW-1:0]]};
   assign m_axis_tlast  = (beat_cnt == LAST_IDX);
   assign busy          = (state != IDLE);

   // Sequencing FSM: arming, input sample count, frame end and overflow flag.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state    <= IDLE;
         in_cnt   <= '0;
         cont_q   <= CONT_DEFAULT;
         overflow <= 1'b0;
      end else begin
         cont_q <= cont_next;
         if (drop) begin
            overflow <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  overflow <= 1'b0;
               end
            end
            RUN: begin
               // Dropped samples still count so frames end on schedule.
               if (ad_valid) begin
                  if (in_last) begin
                     in_cnt <= '0;
                     if (!cont_next) begin
                        state <= DRAIN;
                     end
                  end else begin
                     in_cnt <= in_cnt + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (rd_en && m_axis_tlast) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO storage; contents need no reset because the pointers gate tvalid.
   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         mem[wr_ptr[AW-1:0]] <= sample_real;
      end
   end

   // FIFO pointers.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Output beat counter and completed-frame counter; only reset clears them.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         beat_cnt  <= '0;
         frame_cnt <= '0;
      end else if (rd_en) begin
         if (m_axis_tlast) begin
            beat_cnt  <= '0;
            frame_cnt <= frame_cnt + 16'd1;
         end else begin
            beat_cnt <= beat_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_adc_frame_packer.sv
// Bench for adc_frame_packer: directed scenarios plus random traffic, all
// checked cycle by cycle against a queue-based behavioural model.
module tb_adc_frame_packer;

   localparam int FL    = 8;
   localparam int DEPTH = 16;
   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_DRAIN = 2;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [9:0]  ad_data = '0;
   logic        ad_valid = 1'b0;
   logic        start = 1'b0;
   logic        cont_mode = 1'b1;
   logic        m_axis_tready = 1'b0;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        busy;
   logic        overflow;
   logic [15:0] frame_cnt;

   adc_frame_packer #(
      .FRAME_LEN   (FL),
      .FIFO_DEPTH  (DEPTH),
      .CONT_DEFAULT(1'b1)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .ad_data      (ad_data),
      .ad_valid     (ad_valid),
      .start        (start),
      .cont_mode    (cont_mode),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready),
      .m_axis_tlast (m_axis_tlast),
      .busy         (busy),
      .overflow     (overflow),
      .frame_cnt    (frame_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model
   logic [15:0] q[$];
   int          m_state = S_IDLE;
   int          m_in = 0;
   int          m_beat = 0;
   logic        m_ovf = 1'b0;
   logic [15:0] m_frames = '0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the current inputs, then
   // clock the DUT and compare every output against the model.
   task automatic step();
      bit full, rd, last, wr, drop, fend;
      if (sys_rst) begin
         q.delete();
         m_state  = S_IDLE;
         m_in     = 0;
         m_beat   = 0;
         m_ovf    = 1'b0;
         m_frames = '0;
      end else begin
         full = (q.size() == DEPTH);
         rd   = (q.size() > 0) && m_axis_tready;
         last = rd && (m_beat == FL - 1);
         wr   = (m_state == S_RUN) && ad_valid && (!full || rd);
         drop = (m_state == S_RUN) && ad_valid && full && !rd;
         fend = (m_state == S_RUN) && ad_valid && (m_in == FL - 1);
         if (rd) begin
            void'(q.pop_front());
            m_beat = (m_beat + 1) % FL;
            if (last) m_frames = m_frames + 16'd1;
         end
         if (wr) q.push_back(16'(int'(ad_data) - 512));
         if (drop) m_ovf = 1'b1;
         case (m_state)
            S_IDLE: if (start) begin
               m_state = S_RUN;
               m_ovf   = 1'b0;
            end
            S_RUN: if (ad_valid) begin
               m_in = (m_in + 1) % FL;
               if (fend && !cont_mode) m_state = S_DRAIN;
            end
            S_DRAIN: if (last) m_state = S_IDLE;
            default: m_state = S_IDLE;
         endcase
      end
      @(posedge sys_clk);
      #1;
      check_val("tvalid", m_axis_tvalid, q.size() > 0);
      if (q.size() > 0) begin
         check_val("tdata", m_axis_tdata, {16'h0000, q[0]});
         check_val("tlast", m_axis_tlast, m_beat == FL - 1);
      end else begin
         check_val("tdata_idle", m_axis_tdata, 32'h0);
      end
      check_val("busy", busy, m_state != S_IDLE);
      check_val("overflow", overflow, m_ovf);
      check_val("frame_cnt", frame_cnt, m_frames);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      ad_valid = 1'b0;
      start = 1'b0;
      step();
      step();
      sys_rst = 1'b0;
   endtask

   int n_beats;

   initial begin
      // reset state
      sys_rst = 1'b1;
      for (int i = 0; i < 3; i++) step();
      check_val("rst_tvalid", m_axis_tvalid, 1'b0);
      check_val("rst_tdata", m_axis_tdata, 32'h0);
      check_val("rst_tlast", m_axis_tlast, 1'b0);
      check_val("rst_busy", busy, 1'b0);
      sys_rst = 1'b0;
      step();

      // single frame, no backpressure
      cont_mode = 1'b0;
      m_axis_tready = 1'b1;
      pulse_start();
      for (int i = 0; i < FL; i++) begin
         ad_valid = 1'b1;
         ad_data  = 10'(10'h200 + i);
         step();
      end
      ad_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check_val("single_frame_cnt", frame_cnt, 16'd1);
      check_val("single_idle", busy, 1'b0);

      // conversion extremes
      do_reset();
      cont_mode = 1'b1;
      m_axis_tready = 1'b0;
      pulse_start();
      ad_valid = 1'b1;
      ad_data = 10'h000;
      step();
      ad_data = 10'h3FF;
      step();
      ad_valid = 1'b0;
      check_val("conv_min", m_axis_tdata, 32'h0000_FE00);
      m_axis_tready = 1'b1;
      step();
      check_val("conv_max", m_axis_tdata, 32'h0000_01FF);
      step();

      // backpressure with overflow
      do_reset();
      cont_mode = 1'b1;
      m_axis_tready = 1'b0;
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         ad_valid = 1'b1;
         ad_data  = 10'($urandom_range(0, 1023));
         step();
      end
      ad_valid = 1'b0;
      check_val("bp_overflow", overflow, 1'b1);
      m_axis_tready = 1'b1;
      for (int i = 0; i < 20; i++) step();
      check_val("bp_frames", frame_cnt, 16'd2);

      // continuous mode, three frames
      do_reset();
      cont_mode = 1'b1;
      pulse_start();
      for (int i = 0; i < 3 * FL; i++) begin
         ad_valid = 1'b1;
         ad_data  = 10'($urandom_range(0, 1023));
         m_axis_tready = (i % 4 != 3);
         step();
      end
      ad_valid = 1'b0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 30; i++) step();
      check_val("cont_frames", frame_cnt, 16'd3);
      check_val("cont_busy", busy, 1'b1);

      // full FIFO with simultaneous read and write
      do_reset();
      cont_mode = 1'b1;
      m_axis_tready = 1'b0;
      pulse_start();
      for (int i = 0; i < DEPTH; i++) begin
         ad_valid = 1'b1;
         ad_data  = 10'($urandom_range(0, 1023));
         step();
      end
      m_axis_tready = 1'b1;
      ad_data = 10'($urandom_range(0, 1023));
      step();
      ad_valid = 1'b0;
      check_val("full_rw_overflow", overflow, 1'b0);
      n_beats = 0;
      for (int i = 0; i < DEPTH + 4; i++) begin
         if (m_axis_tvalid) n_beats++;
         step();
      end
      check_val("full_rw_occupancy", n_beats, DEPTH);

      // reset mid-frame
      do_reset();
      cont_mode = 1'b0;
      m_axis_tready = 1'b0;
      pulse_start();
      for (int i = 0; i < FL; i++) begin
         ad_valid = 1'b1;
         ad_data  = 10'(10'h180 + i);
         step();
      end
      ad_valid = 1'b0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      sys_rst = 1'b1;
      step();
      check_val("midrst_tvalid", m_axis_tvalid, 1'b0);
      check_val("midrst_frames", frame_cnt, 16'd0);
      sys_rst = 1'b0;
      pulse_start();
      for (int i = 0; i < FL; i++) begin
         ad_valid = 1'b1;
         ad_data  = 10'(10'h100 + i);
         step();
      end
      ad_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      check_val("midrst_next_frame", frame_cnt, 16'd1);

      // random traffic
      do_reset();
      for (int i = 0; i < 800; i++) begin
         sys_rst       = ($urandom_range(0, 249) == 0);
         start         = ($urandom_range(0, 15) == 0);
         cont_mode     = ($urandom_range(0, 3) != 0);
         ad_valid      = $urandom_range(0, 1);
         ad_data       = 10'($urandom_range(0, 1023));
         m_axis_tready = ($urandom_range(0, 3) != 0);
         step();
      end
      sys_rst = 1'b0;
      start = 1'b0;
      ad_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adc_frame_packer.md
ADC_FRAME_PACKER -- requirements
Module: adc_frame_packer

Interface
REQ-001 The module SHALL have parameter FRAME_LEN, default 1024, meaning samples per FFT frame (power of two, 8..65536).
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 16, meaning skid FIFO entries (power of two, 4..64).
REQ-003 The module SHALL have parameter CONT_DEFAULT, default 1, meaning the reset value of continuous mode.
REQ-004 Port sys_clk  input  1  single clock; all logic rising-edge.
REQ-005 Port sys_rst  input  1  reset, synchronous, active-high.
REQ-006 Port ad_data  input  10  ADC sample, offset binary (0x200 = midscale).
REQ-007 Port ad_valid  input  1  sample strobe; ad_data valid in the same cycle.
REQ-008 Port start  input  1  single-cycle pulse that arms capture.
REQ-009 Port cont_mode  input  1  1 = back-to-back frames, 0 = one frame per start.
REQ-010 Port m_axis_tdata  output  32  FFT input word {imag[15:0], real[15:0]}.
REQ-011 Port m_axis_tvalid  output  1  AXI-stream valid.
REQ-012 Port m_axis_tready  input  1  AXI-stream ready from the FFT core.
REQ-013 Port m_axis_tlast  output  1  high on beat FRAME_LEN-1 of each frame.
REQ-014 Port busy  output  1  high while not IDLE.
REQ-015 Port overflow  output  1  sticky: a sample was dropped because the FIFO was full.
REQ-016 Port frame_cnt  output  16  completed frames, wraps 0xFFFF->0x0000.

Function
REQ-017 FSM states SHALL be IDLE, RUN and DRAIN.
REQ-018 IDLE->RUN SHALL occur on the cycle after start=1; start in RUN or DRAIN SHALL be ignored.
REQ-019 In RUN, each ad_valid=1 cycle SHALL write one sample to the FIFO unless the FIFO is full; in IDLE and DRAIN, samples SHALL be discarded.
REQ-020 Sample conversion: real = sign-extend({~ad_data[9], ad_data[8:0]}) to 16 bits; imag = 0; e.g. 0x3FF->0x01FF, 0x000->0xFE00, 0x200->0x0000.
REQ-021 m_axis_tvalid SHALL equal FIFO not-empty, and tdata SHALL be the FIFO head (first-word fall-through).
REQ-022 A beat SHALL transfer when tvalid&tready; once tvalid is high, tdata and tlast SHALL hold until the transfer.
REQ-023 A beat counter SHALL count 0..FRAME_LEN-1 on transfers; tlast SHALL be 1 exactly when the counter is FRAME_LEN-1; the counter SHALL wrap to 0 after a tlast transfer.
REQ-024 The beat counter SHALL only ever reset on sys_rst, so frame alignment survives dropped samples and IDLE gaps.
REQ-025 Input samples SHALL be counted 0..FRAME_LEN-1; when the count reaches FRAME_LEN-1 on a write:
  - with cont_mode=1, the state SHALL stay RUN and the count SHALL wrap;
  - with cont_mode=0, the state SHALL go to DRAIN.
REQ-026 DRAIN->IDLE SHALL occur on the cycle the tlast beat transfers.
REQ-027 frame_cnt SHALL increment on every tlast transfer.
REQ-028 overflow SHALL set when ad_valid=1, the FIFO is full and the state is RUN; it SHALL clear only on sys_rst or on start while in IDLE.
REQ-029 When a sample is dropped, it SHALL still advance the input count so the frame ends on time, but no FIFO write SHALL occur.
REQ-030 A FIFO write and read in the same cycle while full or empty SHALL both take effect.
  - While full, the read frees the slot for the write in that cycle, so no overflow occurs.
  - While empty, the write is visible as tvalid in the next cycle; there is no bypass.
REQ-031 Latency from an accepted ad_valid to tvalid SHALL be exactly 1 cycle when the FIFO is empty.
REQ-032 cont_mode SHALL be sampled on the frame-end write cycle only.

Reset
REQ-033 On sys_rst=1 at a clock edge, the following SHALL hold:
  - state=IDLE; FIFO empty; tvalid=0; tdata=0; tlast=0;
  - busy=0; overflow=0; frame_cnt=0;
  - all counters=0; the continuous-mode register = CONT_DEFAULT.
REQ-034 sys_rst asserted mid-frame SHALL discard FIFO contents with no partial tlast emitted; after reset, the first beat SHALL be beat 0.

Verification
REQ-035 Single frame: FRAME_LEN=8, cont_mode=0, tready=1, start then 8 ad_valid with ad_data=0x200..0x207 -> tdata real 0x0000..0x0007, tlast only on the 8th beat, frame_cnt=1, state returns to IDLE.
REQ-036 Backpressure: tready=0 for 20 cycles with ad_valid every cycle, FIFO_DEPTH=16 -> 16 samples held, overflow=1, tlast still on beat 8 once tready=1.
REQ-037 Continuous: cont_mode=1, 3x FRAME_LEN samples -> three tlast pulses, frame_cnt=3, busy remains 1.
REQ-038 Full+read same cycle: FIFO full, tready=1 with ad_valid=1 -> no overflow, occupancy stays 16.
REQ-039 Reset mid-frame: sys_rst after 3 of 8 beats -> tvalid=0 next cycle; the next frame starts with beat 0 and tlast on its 8th beat.
REQ-040 Conversion: ad_data 0x000 and 0x3FF -> real 0xFE00 and 0x01FF, imag 0x0000.
